// File: rtl/adder_pkg.sv
// Shared widths and operand typedef for the adder pipeline.
// ADDER_PIPE2_EN selects the two-stage nibble-split pipeline.
package adder_pkg;

    localparam int DATA_W = 8;
    localparam int SUM_W  = 9;
    localparam int CNT_W  = 16;
    localparam int NIB_W  = DATA_W / 2;

`ifdef ADDER_PIPE2_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } operand_t;

    // Stage-1 payload of the split pipeline.
    typedef struct packed {
        logic [NIB_W-1:0] a_hi;
        logic [NIB_W-1:0] b_hi;
        logic             c;
        logic [NIB_W-1:0] lo;
    } lo_part_t;

endpackage

// File: rtl/adder_if.sv
// Operand/result handshake bundle plus the transfer counter.
// Producer side is master, adder side is slave.
interface adder_if;
    import adder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out;
    logic [CNT_W-1:0]  txn_count;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out, txn_count
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out, txn_count
    );

endinterface

// File: rtl/adder_stage.sv
// One valid/ready register slot; loads when empty or draining.
// Payload only captured on a load so idle operands never matter.
module adder_stage #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic load;

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/adder_core.sv
// 8+8 -> 9-bit adder pipeline with valid/ready and a transfer counter.
// ADDER_PIPE2_EN: split into low-nibble and high-nibble stages.
module adder_core
    import adder_pkg::*;
(
    input logic   clk,
    input logic   reset,
    adder_if.slave bus
);

    operand_t         op;
    logic             s_ready;
    logic             o_valid;
    logic [SUM_W-1:0] o_data;
    logic [CNT_W-1:0] cnt;

    assign op = '{a: bus.in1, b: bus.in2};

`ifdef ADDER_PIPE2_EN
    localparam int P1_W = $bits(lo_part_t);

    lo_part_t         p1_in;
    lo_part_t         p1_q;
    logic [NIB_W:0]   lo_sum;
    logic [NIB_W:0]   hi_sum;
    logic             v1;
    logic             r1;
    logic [SUM_W-1:0] p2_in;

    assign lo_sum = {1'b0, op.a[NIB_W-1:0]} + {1'b0, op.b[NIB_W-1:0]};

    assign p1_in = '{
        a_hi: op.a[DATA_W-1:NIB_W],
        b_hi: op.b[DATA_W-1:NIB_W],
        c:    lo_sum[NIB_W],
        lo:   lo_sum[NIB_W-1:0]
    };

    adder_stage #(.W(P1_W)) u_s1 (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (bus.in_valid),
        .in_ready  (s_ready),
        .in_data   (p1_in),
        .out_valid (v1),
        .out_ready (r1),
        .out_data  (p1_q)
    );

    assign hi_sum = {1'b0, p1_q.a_hi} + {1'b0, p1_q.b_hi}
                  + {{NIB_W{1'b0}}, p1_q.c};
    assign p2_in  = {hi_sum, p1_q.lo};

    adder_stage #(.W(SUM_W)) u_s2 (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (v1),
        .in_ready  (r1),
        .in_data   (p2_in),
        .out_valid (o_valid),
        .out_ready (bus.out_ready),
        .out_data  (o_data)
    );
`else
    logic [SUM_W-1:0] sum;

    assign sum = {1'b0, op.a} + {1'b0, op.b};

    adder_stage #(.W(SUM_W)) u_s1 (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (bus.in_valid),
        .in_ready  (s_ready),
        .in_data   (sum),
        .out_valid (o_valid),
        .out_ready (bus.out_ready),
        .out_data  (o_data)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (o_valid && bus.out_ready) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = s_ready;
    assign bus.out_valid = o_valid;
    assign bus.out       = o_data;
    assign bus.txn_count = cnt;

endmodule

// File: tb/tb_adder_core.sv
// Self-checking bench for adder_core: vector table, corner sequences,
// random traffic against a queue-based sum model.
module tb_adder_core;
    import adder_pkg::*;

`ifdef ADDER_PIPE2_EN
    localparam int N = 2;
`else
    localparam int N = 1;
`endif

    logic clk;
    logic reset;

    adder_if bus ();

    adder_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int fails;

    logic [8:0]  mq[$];
    logic [15:0] mcnt;
    bit          hold;
    logic [8:0]  hold_out;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] e;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    // Scoreboard: every accepted pair becomes a plain integer sum.
    always @(negedge clk) begin
        if (!reset) begin
            mq.delete();
            mcnt = 16'h0000;
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_data", 32'(bus.out), 32'(hold_out));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (mq.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    chk("result", 32'(bus.out), 32'(mq.pop_front()));
                end
                chk("txn_before", 32'(bus.txn_count), 32'(mcnt));
                mcnt = mcnt + 16'd1;
            end
            if (bus.in_valid && bus.in_ready) begin
                mq.push_back(9'(int'(bus.in1) + int'(bus.in2)));
            end
            hold     = bus.out_valid && !bus.out_ready;
            hold_out = bus.out;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic single(input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] e, input string nm);
        int lat;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.in1       = a;
        bus.in2       = b;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in1      = 'x;
        bus.in2      = 'x;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.out_valid) lat = k;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(N));
        chk({nm, "_sum"}, 32'(bus.out), 32'(e));
        @(posedge clk);
        #1;
        chk({nm, "_txn"}, 32'(bus.txn_count), 32'(mcnt));
    endtask

    initial begin
        int idx;
        int base;
        int nres;
        int cyc[8];
        logic [8:0] val[8];
        bit stale;

        checks = 0;
        fails  = 0;
        tv[0] = '{8'h12, 8'h34, 9'h046};
        tv[1] = '{8'hFF, 8'hFF, 9'h1FE};
        tv[2] = '{8'h0F, 8'h01, 9'h010};
        tv[3] = '{8'h00, 8'h00, 9'h000};
        tv[4] = '{8'h80, 8'h80, 9'h100};
        tv[5] = '{8'hF0, 8'h0F, 9'h0FF};
        tv[6] = '{8'h08, 8'h08, 9'h010};
        tv[7] = '{8'hA5, 8'h5B, 9'h100};

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_txn", 32'(bus.txn_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        foreach (tv[i]) begin
            single(tv[i].a, tv[i].b, tv[i].e, $sformatf("vec%0d", i));
            if (i == 0) chk("first_txn", 32'(bus.txn_count), 32'd1);
        end

        // Back-to-back stream, one result per cycle.
        nres = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8 + N + 4; c++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (c < 8);
            bus.in1      = 8'(c + 1);
            bus.in2      = 8'h10;
            @(negedge clk);
            if (c < 8) chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
            if (bus.out_valid && nres < 8) begin
                cyc[nres] = c;
                val[nres] = bus.out;
                nres++;
            end
        end
        chk("b2b_count", 32'(nres), 32'd8);
        for (int i = 0; i < nres; i++) begin
            chk("b2b_val", 32'(val[i]), 32'(9'h011 + 9'(i)));
            chk("b2b_cycle", 32'(cyc[i]), 32'(N + i));
        end

        // Backpressure: pipeline fills to N then stalls.
        base = int'(mcnt);
        idx = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in1      = 8'(8'h20 + idx);
            bus.in2      = 8'h01;
            @(negedge clk);
            if (bus.in_ready) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'(N));
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_first", 32'(bus.out), 32'h021);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in1       = 8'(8'h20 + idx);
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) idx++;
        for (int c = 0; c < 30 && idx < 8; c++) begin
            @(posedge clk);
            #1;
            bus.in1 = 8'(8'h20 + idx);
            @(negedge clk);
            if (bus.in_ready) idx++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (N + 4) @(negedge clk);
        chk("bp_drained", 32'(mq.size()), 32'd0);
        chk("bp_results", 32'(int'(mcnt) - base), 32'd8);

        // Long run to bring the counter to 0xFFFE, then wrap.
        do_reset();
        idx = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 70000 && idx < 65534; c++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in1      = 8'($urandom);
            bus.in2      = 8'($urandom);
            @(negedge clk);
            if (bus.in_ready) idx++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (N + 3) @(negedge clk);
        chk("long_accepted", 32'(idx), 32'd65534);
        chk("txn_fffe", 32'(bus.txn_count), 32'hFFFE);
        single(8'h01, 8'h02, 9'h003, "wrap1");
        chk("txn_ffff", 32'(bus.txn_count), 32'hFFFF);
        single(8'h7F, 8'h81, 9'h100, "wrap2");
        chk("txn_0000", 32'(bus.txn_count), 32'h0000);

        // Asynchronous reset with the pipeline full.
        bus.out_ready = 1'b0;
        for (int c = 0; c < N + 2; c++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in1      = 8'(8'h40 + c);
            bus.in2      = 8'h02;
        end
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_out", 32'(bus.out), 32'd0);
        chk("async_txn", 32'(bus.txn_count), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
        stale = 1'b0;
        repeat (N + 6) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        chk("no_stale", 32'(stale), 32'd0);
        chk("post_rst_txn", 32'(bus.txn_count), 32'd0);

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in1       = 8'($urandom);
            bus.in2       = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (N + 4) @(negedge clk);
        chk("rand_drained", 32'(mq.size()), 32'd0);
        chk("rand_txn", 32'(bus.txn_count), 32'(mcnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/adder_core.md
ADDER_CORE -- requirements
Module: adder_core

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL have port in_valid, input, 1 bit: operands on in1/in2 are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-005 SHALL have port in1, input, 8 bits: unsigned operand A.
REQ-006 SHALL have port in2, input, 8 bits: unsigned operand B.
REQ-007 SHALL have port out_valid, output, 1 bit: out holds a valid result.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts result this cycle.
REQ-009 SHALL have port out, output, 9 bits: unsigned sum in1+in2, bit 8 = carry.
REQ-010 SHALL have port txn_count, output, 16 bits: number of completed output transfers.

Function
REQ-011 SHALL treat a transfer as occurring on a rising clk edge where valid and ready are both 1 on that side.
REQ-012 SHALL compute out = zero-extended in1 + zero-extended in2, 9 bits, no truncation; 0xFF+0xFF = 0x1FE.
REQ-013 SHALL implement a pipeline of N stages (N=1 default, N=2 per REQ-024), each stage holding at most one entry.
REQ-014 SHALL let a stage load when it is empty or its entry leaves in the same cycle (full-throughput, one result per cycle under no backpressure).
REQ-015 SHALL drive in_ready combinationally as: first stage empty, or first stage advancing this cycle; no combinational path from in1/in2 to in_ready.
REQ-016 SHALL present the first result with out_valid=1 exactly N cycles after the accepting edge when out_ready stays 1.
REQ-017 SHALL hold out and out_valid stable while out_valid=1 and out_ready=0; no result dropped or duplicated.
REQ-018 SHALL deliver results in acceptance order.
REQ-019 SHALL, with all stages full and out_ready=0, deassert in_ready; upon out_ready rising, accept new input in the same cycle the oldest result leaves.
REQ-020 SHALL increment txn_count by 1 on each output transfer, wrapping 0xFFFF -> 0x0000 without flag.
REQ-021 SHALL ignore in1/in2 when in_valid=0 (X on operands must not propagate to out_valid or txn_count).

Reset
REQ-022 SHALL, while reset=0, asynchronously force all stage valid bits to 0, out to 0x000, out_valid to 0, txn_count to 0x0000; in_ready SHALL read 1 one cycle after reset deasserts and stay 0 never longer than backpressure requires.
REQ-023 SHALL discard in-flight entries on reset mid-operation; no result from before reset appears afterwards.

Configuration
REQ-024 SHALL support macro ADDER_PIPE2_EN: when defined, N=2 (stage 1 adds low nibbles and registers sum[3:0], carry, and upper nibbles; stage 2 adds upper nibbles plus carry); when undefined, N=1 (full 8-bit add in one stage); port list identical in both builds.

Structure
REQ-025 SHALL take DATA_W (8), SUM_W (9), CNT_W (16) and a packed typedef for an operand pair from shared package adder_pkg.
REQ-026 SHALL instantiate sub-module adder_stage (one valid/ready register slot, payload-width parameterised) once per pipeline stage.

Verification
REQ-027 SHALL cover: reset release, single in1=0x12, in2=0x34 with out_ready=1 -> out=0x046, out_valid after N cycles, txn_count=1.
REQ-028 SHALL cover: in1=0xFF, in2=0xFF -> out=0x1FE; in1=0x0F, in2=0x01 -> out=0x010 (nibble carry, checks stage-1 carry in PIPE2 build).
REQ-029 SHALL cover: 8 back-to-back inputs 0x01..0x08 with in2=0x10, out_ready=1 -> 8 results 0x011..0x018 on 8 consecutive cycles, in_ready constant 1.
REQ-030 SHALL cover: out_ready=0 for 5 cycles while in_valid=1 -> in_ready falls after N accepts, out holds first result stable; out_ready=1 -> all results in order, none lost.
REQ-031 SHALL cover: preload txn_count to 0xFFFE via 2 fewer transfers in a forced/long run, then 2 transfers -> txn_count 0xFFFF then 0x0000.
REQ-032 SHALL cover: reset=0 asserted mid-stream with N entries in flight -> out_valid=0, txn_count=0 immediately (asynchronous), no stale result after release.
